// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings and handshake FSM states shared by the ALU files.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLTU = 3'd5,
    ALU_MUL  = 3'd6,
    ALU_DIVU = 3'd7
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, ONE, BUSY, DONE} state_e;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider sharing one datapath.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, done_q, done_d;
  logic [WIDTH:0] part, diff;
  // acc holds product (MUL) or partial remainder (DIVU); q holds multiplier or dividend/quotient
  always_comb begin
    part = {acc_q, q_q[WIDTH-1]};
    diff = part - {1'b0, d_q};
    acc_d = acc_q;
    q_d = q_q;
    d_d = d_q;
    cnt_d = cnt_q;
    div_d = div_q;
    done_d = 1'b0;
    if (start) begin
      acc_d = '0;
      q_d = a;
      d_d = b;
      cnt_d = CW'(WIDTH);
      div_d = is_div;
    end else if (cnt_q != '0) begin
      acc_d = div_q ? (diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0]) : (q_q[0] ? acc_q + d_q : acc_q);
      q_d = div_q ? {q_q[WIDTH-2:0], !diff[WIDTH]} : q_q >> 1;
      d_d = div_q ? d_q : d_q << 1;
      cnt_d = cnt_q - CW'(1);
      done_d = cnt_q == CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      q_q <= q_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
  assign result = div_q ? q_q : acc_q;
  assign remainder = div_q ? acc_q : '0;
endmodule

// File: rtl/alu_iterative_muldiv.sv
// alu_iterative_muldiv: handshaked EX-stage ALU; single-cycle ops plus iterative MUL/DIVU.
module alu_iterative_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
  logic zero_q, zero_d, overflow_q, overflow_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] sum, diff, one_res, iter_result, iter_rem;
  logic accept, multi, one_ovf, iter_done;
  alu_op_e op;
  assign op = alu_op_e'(alu_ctrl);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign accept = in_valid && in_ready;
  assign multi = op == ALU_MUL || (op == ALU_DIVU && b != '0);
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk),
    .reset(reset),
    .start(accept && multi),
    .is_div(op == ALU_DIVU),
    .a(a),
    .b(b),
    .done(iter_done),
    .result(iter_result),
    .remainder(iter_rem)
  );
  // the only non-iterative DIVU is b==0, which yields all-ones
  always_comb begin
    sum = a + b;
    diff = a - b;
    one_res = op == ALU_ADD ? sum :
              op == ALU_SUB ? diff :
              op == ALU_AND ? a & b :
              op == ALU_OR  ? a | b :
              op == ALU_SLT ? WIDTH'($signed(a) < $signed(b)) :
              op == ALU_SLTU ? WIDTH'(a < b) : '1;
    one_ovf = op == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
              op == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  end
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    remainder_d = remainder_q;
    zero_d = zero_q;
    overflow_d = overflow_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = multi ? BUSY : ONE;
        if (!multi) begin
          result_d = one_res;
          remainder_d = op == ALU_DIVU ? a : '0;
          zero_d = one_res == '0;
          overflow_d = one_ovf;
          dbz_d = op == ALU_DIVU;
        end
      end
      ONE: state_d = DONE;
      BUSY: if (iter_done) begin
        state_d = DONE;
        result_d = iter_result;
        remainder_d = iter_rem;
        zero_d = iter_result == '0;
        overflow_d = 1'b0;
        dbz_d = 1'b0;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      result_q <= '0;
      remainder_q <= '0;
      zero_q <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      remainder_q <= remainder_d;
      zero_q <= zero_d;
      overflow_q <= overflow_d;
      dbz_q <= dbz_d;
    end
  end
  assign result = result_q;
  assign remainder = remainder_q;
  assign zero = zero_q;
  assign overflow = overflow_q;
  assign div_by_zero = dbz_q;
endmodule
